// File: rtl/multicore_io_hub.sv
// Multicore I/O hub: broadcasts input samples to an array of cores and
// collects per-core results into one stream through a round-robin arbiter
// and a result FIFO. Each core has one holding slot; a strobe that finds
// the slot still occupied (and not being granted) is dropped and counted.
module multicore_io_hub #(
  parameter int NCORES     = 72,
  parameter int IN_W       = 19,
  parameter int OUT_W      = 28,
  parameter int FIFO_DEPTH = 16,
  parameter int ID_W       = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_W-1:0]         s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [IN_W-1:0]         core_in,
  input  logic [NCORES-1:0]       core_req,
  input  logic [NCORES*OUT_W-1:0] core_out,
  input  logic [NCORES-1:0]       core_en,
  output logic [OUT_W-1:0]        m_data,
  output logic [ID_W-1:0]         m_id,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    underrun,
  output logic                    overflow,
  output logic [15:0]             drop_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = ID_W + OUT_W;
  localparam int DW = $clog2(NCORES + 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NCORES - 1);

  // Saturating add of this cycle's drop count onto the 16-bit counter.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [DW-1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(b);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Input holding register and status flops
  logic              loaded_q, loaded_d;
  logic [IN_W-1:0]   core_in_q, core_in_d;
  logic              underrun_q, underrun_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  // Per-core holding slots and arbiter history
  logic [NCORES-1:0] pend_q, pend_d;
  logic [OUT_W-1:0]  hold_q [NCORES];
  logic [OUT_W-1:0]  hold_d [NCORES];
  logic [ID_W-1:0]   last_grant_q, last_grant_d;

  // Result FIFO
  logic [EW-1:0]     mem_q [FIFO_DEPTH];
  logic [EW-1:0]     mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Combinational helpers
  logic              any_req_s;
  logic              xfer_s;
  logic              pop_s;
  logic              push_ok_s;
  logic              lo_found_s, hi_found_s;
  logic [ID_W-1:0]   lo_idx_s, hi_idx_s;
  logic              grant_vld_s;
  logic [ID_W-1:0]   grant_idx_s;
  logic [EW-1:0]     push_data_s;
  logic [NCORES-1:0] drop_s;
  logic [DW-1:0]     drop_num_s;

  assign any_req_s   = |core_req;
  assign s_ready     = !rst && (!loaded_q || any_req_s);
  assign xfer_s      = s_valid && s_ready;
  assign m_valid     = (count_q != {CW{1'b0}});
  assign pop_s       = m_valid && m_ready;
  // A full FIFO can still take an entry when the head leaves on the same edge.
  assign push_ok_s   = (count_q != FULL_CNT) || pop_s;
  assign grant_vld_s = lo_found_s && push_ok_s;
  assign grant_idx_s = hi_found_s ? hi_idx_s : lo_idx_s;

  assign core_in  = core_in_q;
  assign m_id     = mem_q[rd_ptr_q][EW-1:OUT_W];
  assign m_data   = mem_q[rd_ptr_q][OUT_W-1:0];
  assign underrun = underrun_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  // Sample holding register: load on transfer, release on consumption.
  always_comb begin
    loaded_d  = loaded_q;
    core_in_d = core_in_q;
    if (xfer_s) begin
      loaded_d  = 1'b1;
      core_in_d = s_data;
    end else if (any_req_s) begin
      loaded_d  = 1'b0;
    end else begin
      loaded_d  = loaded_q;
    end
    underrun_d = underrun_q | (any_req_s & ~loaded_q);
  end

  // Round-robin search: lowest pending index above last_grant, else lowest overall.
  always_comb begin
    lo_found_s = 1'b0;
    hi_found_s = 1'b0;
    lo_idx_s   = {ID_W{1'b0}};
    hi_idx_s   = {ID_W{1'b0}};
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        lo_found_s = 1'b1;
        lo_idx_s   = ID_W'(i);
        if (i > int'(last_grant_q)) begin
          hi_found_s = 1'b1;
          hi_idx_s   = ID_W'(i);
        end else begin
          hi_found_s = hi_found_s;
        end
      end else begin
        lo_found_s = lo_found_s;
      end
    end
  end

  // Per-core slot update: grant frees the slot (a same-edge strobe refills it),
  // a strobe into an occupied, ungranted slot is dropped.
  always_comb begin
    pend_d      = pend_q;
    hold_d      = hold_q;
    drop_s      = {NCORES{1'b0}};
    push_data_s = {EW{1'b0}};
    drop_num_s  = {DW{1'b0}};
    for (int i = 0; i < NCORES; i++) begin
      if (grant_vld_s && (int'(grant_idx_s) == i)) begin
        push_data_s = {ID_W'(i), hold_q[i]};
        hold_d[i]   = core_en[i] ? core_out[i*OUT_W +: OUT_W] : hold_q[i];
        pend_d[i]   = core_en[i];
      end else if (core_en[i] && pend_q[i]) begin
        drop_s[i]   = 1'b1;
      end else if (core_en[i]) begin
        hold_d[i]   = core_out[i*OUT_W +: OUT_W];
        pend_d[i]   = 1'b1;
      end else begin
        pend_d[i]   = pend_q[i];
      end
      drop_num_s = drop_num_s + DW'(drop_s[i]);
    end
  end

  // Drop bookkeeping and arbiter history.
  always_comb begin
    overflow_d   = overflow_q | (|drop_s);
    drop_cnt_d   = sat_add16(drop_cnt_q, drop_num_s);
    last_grant_d = grant_vld_s ? grant_idx_s : last_grant_q;
  end

  // Result FIFO write, read and occupancy tracking.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (grant_vld_s) begin
      mem_d[wr_ptr_q] = push_data_s;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({grant_vld_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_q     <= 1'b0;
      core_in_q    <= {IN_W{1'b0}};
      underrun_q   <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= 16'h0000;
      pend_q       <= {NCORES{1'b0}};
      hold_q       <= '{default: '0};
      last_grant_q <= LAST_RST;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      count_q      <= {CW{1'b0}};
    end else begin
      loaded_q     <= loaded_d;
      core_in_q    <= core_in_d;
      underrun_q   <= underrun_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      pend_q       <= pend_d;
      hold_q       <= hold_d;
      last_grant_q <= last_grant_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

endmodule

// File: tb/tb_multicore_io_hub.sv
// Self-checking bench for multicore_io_hub: directed scenarios followed by
// randomized traffic, checked by a scoreboard fed from a behavioural model.
module tb_multicore_io_hub;

  localparam int NCORES     = 72;
  localparam int IN_W       = 19;
  localparam int OUT_W      = 28;
  localparam int FIFO_DEPTH = 16;
  localparam int ID_W       = 7;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [IN_W-1:0]         s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic [IN_W-1:0]         core_in;
  logic [NCORES-1:0]       core_req;
  logic [NCORES*OUT_W-1:0] core_out;
  logic [NCORES-1:0]       core_en;
  logic [OUT_W-1:0]        m_data;
  logic [ID_W-1:0]         m_id;
  logic                    m_valid;
  logic                    m_ready;
  logic                    underrun;
  logic                    overflow;
  logic [15:0]             drop_cnt;

  always #5 clk = ~clk;

  multicore_io_hub #(
    .NCORES(NCORES), .IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .core_in(core_in), .core_req(core_req), .core_out(core_out), .core_en(core_en),
    .m_data(m_data), .m_id(m_id), .m_valid(m_valid), .m_ready(m_ready),
    .underrun(underrun), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [OUT_W-1:0] data;
  } res_t;

  // Expected results not yet seen leaving the DUT, in output order.
  res_t exp_q[$];

  // Behavioural reference state
  bit               mdl_pend [NCORES];
  logic [OUT_W-1:0] mdl_hold [NCORES];
  int               mdl_last = NCORES - 1;
  int               mdl_occ = 0;
  bit               mdl_loaded = 1'b0;
  logic [IN_W-1:0]  mdl_core_in = '0;
  bit               mdl_underrun = 1'b0;
  bit               mdl_overflow = 1'b0;
  int               mdl_drops = 0;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  int drain_cnt = 0;
  int id5_seen = 0;
  logic [OUT_W-1:0] id5_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core_out(input int c, input int v);
    core_out[c*OUT_W +: OUT_W] = OUT_W'(v);
  endtask

  // Reference model: one clock edge of the hub, stated as grant-then-capture.
  task automatic model_step();
    bit any_req;
    bit pop;
    int g;
    res_t r;
    if (rst) begin
      for (int i = 0; i < NCORES; i++) begin
        mdl_pend[i] = 1'b0;
        mdl_hold[i] = '0;
      end
      mdl_last = NCORES - 1;
      mdl_occ = 0;
      exp_q.delete();
      mdl_loaded = 1'b0;
      mdl_core_in = '0;
      mdl_underrun = 1'b0;
      mdl_overflow = 1'b0;
      mdl_drops = 0;
    end else begin
      any_req = (core_req != '0);
      if (any_req && !mdl_loaded) mdl_underrun = 1'b1;
      if (s_valid && (!mdl_loaded || any_req)) begin
        mdl_core_in = s_data;
        mdl_loaded = 1'b1;
      end else if (any_req) begin
        mdl_loaded = 1'b0;
      end
      pop = (mdl_occ > 0) && m_ready;
      g = -1;
      if (mdl_occ < FIFO_DEPTH || pop) begin
        for (int k = 1; k <= NCORES; k++) begin
          if (mdl_pend[(mdl_last + k) % NCORES]) begin
            g = (mdl_last + k) % NCORES;
            break;
          end
        end
      end
      if (g >= 0) begin
        r.id = ID_W'(g);
        r.data = mdl_hold[g];
        exp_q.push_back(r);
        mdl_pend[g] = 1'b0;
        mdl_last = g;
      end
      for (int i = 0; i < NCORES; i++) begin
        if (core_en[i]) begin
          if (mdl_pend[i]) begin
            mdl_overflow = 1'b1;
            if (mdl_drops < 65535) mdl_drops++;
          end else begin
            mdl_pend[i] = 1'b1;
            mdl_hold[i] = core_out[i*OUT_W +: OUT_W];
          end
        end
      end
      mdl_occ = mdl_occ + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
    end
  endtask

  always @(posedge clk) model_step();

  // Monitor: compare status every cycle, pop the scoreboard on each handshake.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", m_valid, (mdl_occ != 0));
      chk("s_ready", s_ready, (!rst && (!mdl_loaded || core_req != '0)));
      chk("core_in", core_in, mdl_core_in);
      chk("underrun", underrun, mdl_underrun);
      chk("overflow", overflow, mdl_overflow);
      chk("drop_cnt", drop_cnt, mdl_drops);
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got id=%0d data=%0h expected no output", m_id, m_data);
        end else begin
          chk("m_id", m_id, exp_q[0].id);
          chk("m_data", m_data, exp_q[0].data);
          if (m_ready) begin
            void'(exp_q.pop_front());
            drain_cnt++;
            if (m_id == ID_W'(5)) begin
              id5_seen++;
              id5_data = m_data;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [IN_W-1:0]  neg5;
    logic [OUT_W-1:0] v;
    rst = 1'b1;
    s_data = '0;
    s_valid = 1'b0;
    core_req = '0;
    core_out = '0;
    core_en = '0;
    m_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_id", m_id, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_core_in", core_in, 0);
    rst = 1'b0;
    tick();

    // Sample path and underrun
    neg5 = -19'sd5;
    s_data = neg5;
    s_valid = 1'b1;
    #1 chk("t39_s_ready", s_ready, 1'b1);
    tick();
    s_valid = 1'b0;
    chk("t39_core_in", core_in, neg5);
    core_req[3] = 1'b1;
    tick();
    core_req = '0;
    chk("t39_released", s_ready, 1'b1);
    chk("t39_no_underrun", underrun, 1'b0);
    core_req[3] = 1'b1;
    tick();
    core_req = '0;
    chk("t39_underrun", underrun, 1'b1);
    chk("t39_core_in_held", core_in, neg5);

    // Simultaneous strobes on cores 0, 1, 71
    m_ready = 1'b1;
    set_core_out(0, 10);
    set_core_out(1, -20);
    set_core_out(71, 30);
    core_en[0] = 1'b1;
    core_en[1] = 1'b1;
    core_en[71] = 1'b1;
    tick();
    core_en = '0;
    chk("t40_e0_valid", m_valid, 1'b0);
    tick();
    v = 28'd10;
    chk("t40_first_valid", m_valid, 1'b1);
    chk("t40_first_id", m_id, 0);
    chk("t40_first_data", m_data, v);
    tick();
    v = -28'sd20;
    chk("t40_second_id", m_id, 1);
    chk("t40_second_data", m_data, v);
    tick();
    v = 28'd30;
    chk("t40_third_id", m_id, 71);
    chk("t40_third_data", m_data, v);
    tick();
    chk("t40_empty", m_valid, 1'b0);

    // Backpressure: 20 strobes, 16 queued, 4 pending
    m_ready = 1'b0;
    for (int j = 0; j < 20; j++) begin
      set_core_out(10 + j * 3, 1000 + j);
      core_en = '0;
      core_en[10 + j * 3] = 1'b1;
      tick();
    end
    core_en = '0;
    repeat (8) tick();
    chk("t41_no_drops", drop_cnt, 0);
    chk("t41_no_overflow", overflow, 1'b0);
    drain_cnt = 0;
    m_ready = 1'b1;
    repeat (30) tick();
    chk("t41_drained", drain_cnt, 20);

    // Drop on a full FIFO
    m_ready = 1'b0;
    for (int c = 40; c < 56; c++) begin
      set_core_out(c, 2000 + c);
      core_en[c] = 1'b1;
    end
    tick();
    core_en = '0;
    repeat (18) tick();
    set_core_out(5, 111);
    core_en[5] = 1'b1;
    tick();
    core_en = '0;
    repeat (3) tick();
    set_core_out(5, 222);
    core_en[5] = 1'b1;
    tick();
    core_en = '0;
    chk("t42_overflow", overflow, 1'b1);
    chk("t42_drop_cnt", drop_cnt, 1);
    id5_seen = 0;
    m_ready = 1'b1;
    repeat (25) tick();
    chk("t42_core5_count", id5_seen, 1);
    chk("t42_core5_value", id5_data, 111);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Grant edge coinciding with a new strobe
    m_ready = 1'b1;
    set_core_out(2, 7);
    core_en[2] = 1'b1;
    tick();
    set_core_out(2, 9);
    tick();
    core_en = '0;
    chk("t43_first_id", m_id, 2);
    chk("t43_first_data", m_data, 7);
    tick();
    chk("t43_second_id", m_id, 2);
    chk("t43_second_data", m_data, 9);
    chk("t43_no_drop", drop_cnt, 0);
    tick();

    // Reset mid-stream: 5 queued, 3 pending
    m_ready = 1'b0;
    for (int c = 20; c < 28; c++) begin
      set_core_out(c, 500 + c);
      core_en[c] = 1'b1;
    end
    tick();
    core_en = '0;
    repeat (5) tick();
    chk("t44_pre_valid", m_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t44_valid_cleared", m_valid, 1'b0);
    chk("t44_m_data", m_data, 0);
    chk("t44_m_id", m_id, 0);
    chk("t44_drop_cnt", drop_cnt, 0);
    chk("t44_overflow", overflow, 1'b0);
    chk("t44_underrun", underrun, 1'b0);
    drain_cnt = 0;
    m_ready = 1'b1;
    repeat (20) tick();
    chk("t44_no_stale", drain_cnt, 0);

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NCORES; c++) begin
        core_out[c*OUT_W +: OUT_W] = OUT_W'($urandom);
      end
      core_en = '0;
      for (int c = 0; c < NCORES; c++) begin
        if ($urandom_range(0, 99) < 1) core_en[c] = 1'b1;
      end
      core_req = '0;
      if ($urandom_range(0, 3) == 0) core_req[$urandom_range(0, NCORES - 1)] = 1'b1;
      s_valid = ($urandom_range(0, 1) == 1);
      s_data = IN_W'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;
    core_en = '0;
    core_req = '0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (200) tick();
    chk("final_sb_empty", exp_q.size(), 0);
    chk("final_m_valid", m_valid, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicore_io_hub.md
MULTICORE_IO_HUB -- requirements
Module: multicore_io_hub

Interface
REQ-001 Parameter NCORES, 72, number of attached cores (2..128).
REQ-002 Parameter IN_W, 19, signed input sample width.
REQ-003 Parameter OUT_W, 28, signed core result width.
REQ-004 Parameter FIFO_DEPTH, 16, result FIFO entries (power of 2, >=2).
REQ-005 Parameter ID_W, 7, core-index width (>= clog2(NCORES)).
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 s_data  in  IN_W  incoming sample.
REQ-009 s_valid  in  1  s_data valid.
REQ-010 s_ready  out  1  hub can accept a sample.
REQ-011 core_in  out  IN_W  sample broadcast to all cores.
REQ-012 core_req  in  NCORES  per-core request to consume core_in.
REQ-013 core_out  in  NCORES*OUT_W  core results, core i at bits [i*OUT_W +: OUT_W].
REQ-014 core_en  in  NCORES  per-core one-cycle result strobe.
REQ-015 m_data  out  OUT_W  FIFO head result.
REQ-016 m_id  out  ID_W  index of the core that produced m_data.
REQ-017 m_valid / m_ready  out / in  1  result stream handshake.
REQ-018 underrun  out  1  sticky: a core requested while no sample was loaded.
REQ-019 overflow  out  1  sticky: a result was dropped.
REQ-020 drop_cnt  out  16  dropped-result count, saturating at 16'hFFFF.

Function
REQ-021 Input holding register: a sample transfers when s_valid && s_ready; core_in <= s_data and loaded <= 1 on the next edge.
REQ-022 s_ready = !rst && (!loaded || |core_req), combinational.
REQ-023 Sample consumption: when |core_req && loaded, loaded clears unless a new transfer occurs on the same edge; in that case core_in takes the new sample and loaded stays 1.
REQ-024 Underrun: when |core_req && !loaded, underrun sets; core_in holds its value.
REQ-025 Capture: core_en[i] at edge E loads hold[i] from slice i of core_out and sets pend[i].
REQ-026 Drop: when core_en[i] is high, pend[i] is 1, and core i is not granted this cycle, the new value is discarded, hold[i] is unchanged, overflow sets, and drop_cnt increments.
REQ-027 Grant plus new strobe: when core i is granted and core_en[i] is high on the same edge, hold[i] takes the new value, pend[i] stays 1, and no drop occurs.
REQ-028 Arbiter: at most one grant per cycle, issued only when a push is allowed.
  - Round-robin search starts at last_grant+1 and wraps from NCORES-1 to 0.
  - last_grant resets to NCORES-1, so core 0 has first priority.
REQ-029 A grant pushes {i, hold[i]} into the FIFO and clears pend[i], subject to REQ-027.
REQ-030 Push allowed: FIFO not full, or a pop occurs on the same edge.
REQ-031 Pop: occurs when m_valid && m_ready; simultaneous push and pop keeps occupancy constant at any fill level.
REQ-032 m_valid = FIFO not empty; m_data and m_id show the head entry and stay stable while m_valid && !m_ready.
REQ-033 Latency: core_en at edge E0 with empty FIFO and no other pend gives m_valid high after edge E0+1.
REQ-034 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.
REQ-035 Result ordering: results from a single core exit in capture order; ordering across cores follows grant order.

Reset
REQ-036 While rst is sampled high, state clears on the edge:
  - loaded=0, core_in=0, pend=0, last_grant=NCORES-1.
  - FIFO emptied; m_valid=0, m_data=0, m_id=0.
  - underrun=0, overflow=0, drop_cnt=0.
REQ-037 s_ready=0 while rst is high; no transfers, captures or grants occur during reset.
REQ-038 Reset asserted mid-operation discards FIFO contents and pending results with no partial output.

Verification
REQ-039 Sample path: after reset, s_data=-5 with s_valid=1 for one cycle -> core_in=-5 and s_ready=1; core_req[3]=1 for one cycle -> loaded clears; a further core_req pulse -> underrun=1.
REQ-040 Simultaneous strobes: core_en[0], [1] and [71] pulse together with values 10, -20, 30, m_ready=1 -> m_id/m_data stream 0/10, 1/-20, 71/30 on consecutive cycles, first entry valid 2 edges after the strobe.
REQ-041 Backpressure: m_ready=0 and 20 single-core strobes spread across different cores -> FIFO holds 16 entries, 4 stay pending, no drops; raising m_ready drains all 20 in grant order.
REQ-042 Drop: m_ready=0, FIFO full, core 5 strobed twice -> second value dropped, overflow=1, drop_cnt=1; core 5 later emits the first value only.
REQ-043 Grant plus new strobe: core 2 pending with value 7 and re-strobed with 9 on its grant edge -> 7 then 9 emitted, drop_cnt=0.
REQ-044 Reset mid-stream: rst pulses with 5 FIFO entries and 3 pending -> m_valid=0 on the next cycle, all counters 0, and no stale entries appear afterwards.
